snake_move_ctrl: RTL and testbench



---
 rtl/snake_pkg.sv | 36 +++
 rtl/snake_dir_fifo.sv | 86 ++++++++
 rtl/snake_move_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and constants for the snake game sequencer
//
// Purpose: direction and FSM state encodings, the opposite-direction helper
//          and the reset pose of the snake.
// Ports:   none (package)
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // FSM encoding kept as plain constants so legacy code can compare raw bits.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DEAD = 2'd2;

    // Reset pose: horizontal snake, head at (35,32), body trailing to the left.
    localparam int   RST_HEAD_X = 35;
    localparam int   RST_HEAD_Y = 32;
    localparam dir_t RST_DIR    = DIR_RIGHT;
    localparam int   NUM_SEGS   = 4;

    function automatic dir_t dir_opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// rtl/snake_dir_fifo.sv - 2-entry direction request buffer with push filtering
//
// Purpose: queues up to two direction requests between movement steps.
//          A request equal or opposite to the reference direction (newest
//          buffered entry, else cur_dir) is dropped, as is any request while
//          full. A push in the same cycle as a pop is applied first, so an
//          empty buffer can hand the new request straight to the pop.
// Ports:   clk, rst_n      clock, async active-low reset
//          clear           empty the buffer (wins over push/pop)
//          push, push_dir  request strobe and its direction
//          cur_dir         direction currently being travelled
//          pop             take the oldest entry this cycle
//          pop_valid       an entry is being taken this cycle
//          pop_dir         the entry being taken
module snake_dir_fifo
    import snake_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic push,
    input  dir_t push_dir,
    input  dir_t cur_dir,
    input  logic pop,
    output logic pop_valid,
    output dir_t pop_dir
);

    dir_t       q0, q1;
    logic [1:0] count;

    dir_t       ref_dir;
    logic       accept;
    dir_t       a0, a1, n0, n1;
    logic [1:0] acnt, ncnt;

    always_comb begin
        if (count == 2'd2)
            ref_dir = q1;
        else if (count == 2'd1)
            ref_dir = q0;
        else
            ref_dir = cur_dir;

        accept = push && (count != 2'd2) &&
                 (push_dir != ref_dir) && (push_dir != dir_opposite(ref_dir));

        // state after the push
        a0   = q0;
        a1   = q1;
        acnt = count;
        if (accept) begin
            if (count == 2'd0)
                a0 = push_dir;
            else
                a1 = push_dir;
            acnt = count + 2'd1;
        end

        // then the pop
        pop_valid = pop && (acnt != 2'd0);
        pop_dir   = a0;
        n0   = a0;
        n1   = a1;
        ncnt = acnt;
        if (pop_valid) begin
            n0   = a1;
            ncnt = acnt - 2'd1;
        end
        if (clear)
            ncnt = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0    <= RST_DIR;
            q1    <= RST_DIR;
            count <= 2'd0;
        end else begin
            q0    <= n0;
            q1    <= n1;
            count <= ncnt;
        end
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// rtl/snake_move_ctrl.sv - snake game-logic sequencer (movement, FSM, blanking)
//
// Purpose: paces movement with a free-running frame tick, buffers button
//          direction requests, shifts the four segment coordinates and runs
//          the IDLE/RUN/DEAD game flow including the death blink.
// Config:  SNAKE_WRAP_EN defined   -> coordinates wrap, no wall death
//          SNAKE_WRAP_EN undefined -> leaving the grid sends the FSM to DEAD
// Ports:   clk, rst_n                    clock, async active-low reset
//          start                         begin / restart a game (pulse)
//          btn_up/down/left/right        direction request pulses
//          px1..px4, py1..py4            segment coordinates, 1 = head
//          all_black                     blank-screen request
//          game_over                     high while in DEAD
//          tick                          one-cycle pulse per movement step
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV    = 10000000,
    parameter int BLINK_TICKS = 6,
    parameter int COORD_W     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    output logic [COORD_W-1:0] px1,
    output logic [COORD_W-1:0] px2,
    output logic [COORD_W-1:0] px3,
    output logic [COORD_W-1:0] px4,
    output logic [COORD_W-1:0] py1,
    output logic [COORD_W-1:0] py2,
    output logic [COORD_W-1:0] py3,
    output logic [COORD_W-1:0] py4,
    output logic               all_black,
    output logic               game_over,
    output logic               tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int BLK_W = (BLINK_TICKS > 0) ? $clog2(BLINK_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);

    logic [CNT_W-1:0]   cnt;
    state_t             state;
    dir_t               cur_dir;
    logic [BLK_W-1:0]   blink_cnt;
    logic [COORD_W-1:0] seg_x [1:NUM_SEGS];
    logic [COORD_W-1:0] seg_y [1:NUM_SEGS];

    logic               req_valid;
    dir_t               req_dir;
    logic               fifo_clear;
    logic               step_en;
    logic               pop_valid;
    dir_t               pop_dir;
    dir_t               move_dir;
    logic [COORD_W-1:0] new_x, new_y;
    logic               wall_hit;

    assign tick      = (cnt == CNT_LAST);
    assign game_over = (state == ST_DEAD);

    assign px1 = seg_x[1];
    assign px2 = seg_x[2];
    assign px3 = seg_x[3];
    assign px4 = seg_x[4];
    assign py1 = seg_y[1];
    assign py2 = seg_y[2];
    assign py3 = seg_y[3];
    assign py4 = seg_y[4];

    // start outranks both the tick and any button in the same cycle.
    assign step_en    = (state == ST_RUN) && tick && !start;
    assign fifo_clear = start || (state != ST_RUN);

    always_comb begin
        req_valid = (state == ST_RUN) && !start &&
                    (btn_up || btn_down || btn_left || btn_right);
        if (btn_up)
            req_dir = DIR_UP;
        else if (btn_down)
            req_dir = DIR_DOWN;
        else if (btn_left)
            req_dir = DIR_LEFT;
        else
            req_dir = DIR_RIGHT;
    end

    snake_dir_fifo u_dir_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (fifo_clear),
        .push      (req_valid),
        .push_dir  (req_dir),
        .cur_dir   (cur_dir),
        .pop       (step_en),
        .pop_valid (pop_valid),
        .pop_dir   (pop_dir)
    );

    assign move_dir = pop_valid ? pop_dir : cur_dir;

    // Natural COORD_W-bit overflow gives the wrap-around coordinates.
    always_comb begin
        new_x = seg_x[1];
        new_y = seg_y[1];
        case (move_dir)
            DIR_UP:   new_y = seg_y[1] - C_ONE;
            DIR_DOWN: new_y = seg_y[1] + C_ONE;
            DIR_LEFT: new_x = seg_x[1] - C_ONE;
            default:  new_x = seg_x[1] + C_ONE;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall_hit = 1'b0;
`else
    always_comb begin
        case (move_dir)
            DIR_UP:   wall_hit = (seg_y[1] == '0);
            DIR_DOWN: wall_hit = (seg_y[1] == '1);
            DIR_LEFT: wall_hit = (seg_x[1] == '0);
            default:  wall_hit = (seg_x[1] == '1);
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            state     <= ST_IDLE;
            cur_dir   <= RST_DIR;
            all_black <= 1'b0;
            blink_cnt <= '0;
            for (int i = 1; i <= NUM_SEGS; i++) begin
                seg_x[i] <= COORD_W'(RST_HEAD_X - (i - 1));
                seg_y[i] <= COORD_W'(RST_HEAD_Y);
            end
        end else begin
            if (start || tick)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if (start) begin
                // Same restart from every state: reset pose, straight into RUN.
                state     <= ST_RUN;
                cur_dir   <= RST_DIR;
                all_black <= 1'b0;
                blink_cnt <= '0;
                for (int i = 1; i <= NUM_SEGS; i++) begin
                    seg_x[i] <= COORD_W'(RST_HEAD_X - (i - 1));
                    seg_y[i] <= COORD_W'(RST_HEAD_Y);
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (step_en) begin
                            cur_dir <= move_dir;
                            if (wall_hit) begin
                                // Segments freeze in the last legal pose.
                                state     <= ST_DEAD;
                                blink_cnt <= BLK_W'(BLINK_TICKS);
                            end else begin
                                for (int i = NUM_SEGS; i > 1; i--) begin
                                    seg_x[i] <= seg_x[i-1];
                                    seg_y[i] <= seg_y[i-1];
                                end
                                seg_x[1] <= new_x;
                                seg_y[1] <= new_y;
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (blink_cnt == '0) begin
                            all_black <= 1'b1;
                        end else if (tick) begin
                            all_black <= ~all_black;
                            blink_cnt <= blink_cnt - BLK_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb/tb_snake_move_ctrl.sv - directed self-checking bench for snake_move_ctrl
module tb_snake_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, btn_up, btn_down, btn_left, btn_right;
    logic [5:0] px1, px2, px3, px4, py1, py2, py3, py4;
    logic       all_black, game_over, tick;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    snake_move_ctrl #(
        .TICK_DIV    (4),
        .BLINK_TICKS (4),
        .COORD_W     (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .px1       (px1),
        .px2       (px2),
        .px3       (px3),
        .px4       (px4),
        .py1       (py1),
        .py2       (py2),
        .py3       (py3),
        .py4       (py4),
        .all_black (all_black),
        .game_over (game_over),
        .tick      (tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until tick is high (bounded); steps taken returned in cnt.
    task automatic wait_tick(output int cnt);
        cnt = 0;
        while (!tick && cnt < 20) begin
            step();
            cnt++;
        end
        if (!tick) begin
            total++;
            assert (tick === 1'b1) else begin
                bad++;
                $error("FAIL tick_timeout observed=%0d expected=1", tick);
            end
        end
    endtask

    task automatic move();
        int k;
        wait_tick(k);
        step();
    endtask

    task automatic pulse(input int which);
        btn_up    = (which == 0);
        btn_down  = (which == 1);
        btn_left  = (which == 2);
        btn_right = (which == 3);
        step();
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    endtask

    initial begin
        rst_n = 0; start = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_px1", px1, 35);
        chk("rst_py1", py1, 32);
        chk("rst_px4", px4, 32);
        chk("rst_all_black", all_black, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_tick", tick, 0);
        rst_n = 1;
        step();

        // start, three plain ticks to the right
        start = 1; step(); start = 0;
        wait_tick(n); chk("tick_period_1", n, 3);
        step(); chk("mv1_px1", px1, 36); chk("mv1_py1", py1, 32);
        chk("tick_low_after", tick, 0);
        wait_tick(n); chk("tick_period_2", n, 3);
        step(); chk("mv2_px1", px1, 37);
        move(); chk("mv3_px1", px1, 38); chk("mv3_px4", px4, 35);

        // reversal is dropped
        pulse(2);
        move(); chk("rev_px1", px1, 39); chk("rev_py1", py1, 32);

        // up, left queued; down dropped because buffer is full
        pulse(0); pulse(2); pulse(1);
        chk("q_tick_now", tick, 1);
        step(); chk("q1_px1", px1, 39); chk("q1_py1", py1, 31);
        move(); chk("q2_px1", px1, 38); chk("q2_py1", py1, 31);
        move(); chk("q3_px1", px1, 37); chk("q3_py1", py1, 31);

        // steer to row 30 heading right, then run to x = 63
        pulse(0); move(); chk("st_py1", py1, 30); chk("st_px1", px1, 37);
        pulse(3); move(); chk("st2_px1", px1, 38);
        for (int i = 1; i <= 25; i++) move();
        chk("edge_px1", px1, 63); chk("edge_px4", px4, 60);

`ifdef SNAKE_WRAP_EN
        move();
        chk("wrap_px1", px1, 0); chk("wrap_py1", py1, 30);
        chk("wrap_px2", px2, 63); chk("wrap_game_over", game_over, 0);
`else
        move();
        chk("wall_px1", px1, 63); chk("wall_px4", px4, 60); chk("wall_py1", py1, 30);
        chk("wall_game_over", game_over, 1);
        chk("wall_all_black", all_black, 0);
        move(); chk("blink1", all_black, 1);
        move(); chk("blink2", all_black, 0);
        move(); chk("blink3", all_black, 1);
        move(); chk("blink4", all_black, 0);
        move(); chk("blink_hold", all_black, 1);
        chk("dead_px1", px1, 63); chk("dead_game_over", game_over, 1);
        start = 1; step(); start = 0;
        chk("restart_px1", px1, 35); chk("restart_py1", py1, 32);
        chk("restart_px4", px4, 32);
        chk("restart_all_black", all_black, 0);
        chk("restart_game_over", game_over, 0);
        wait_tick(n); chk("restart_tick_period", n, 3);
        step(); chk("restart_run_px1", px1, 36);
`endif

        // start together with tick and btn_up
        wait_tick(n);
        start = 1; btn_up = 1; step(); start = 0; btn_up = 0;
        chk("sim_px1", px1, 35); chk("sim_py1", py1, 32); chk("sim_px4", px4, 32);
        wait_tick(n); chk("sim_tick_period", n, 3);
        step(); chk("sim_mv_px1", px1, 36); chk("sim_mv_py1", py1, 32);

        // asynchronous reset mid-game
        move(); chk("pre_rst_px1", px1, 37);
        wait_tick(n);
        #2 rst_n = 0;
        #1;
        chk("arst_tick", tick, 0); chk("arst_px1", px1, 35);
        chk("arst_py1", py1, 32); chk("arst_px4", px4, 32);
        chk("arst_game_over", game_over, 0); chk("arst_all_black", all_black, 0);
        #2 rst_n = 1;
        step();

        // IDLE ignores buttons and holds the pose
        pulse(0);
        move(); chk("idle_px1", px1, 35); chk("idle_py1", py1, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
